// File: rtl/conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// conv_window_scheduler
//
// Sequences one convolution layer. Walks the loop nest
// kernel -> out-row -> out-col -> depth (depth innermost) and issues one window
// command per step to the line-buffer / MAC array over a valid/ready
// handshake. A credit counter bounds the number of output pixels in flight
// (pixels whose last depth slice was accepted but whose result has not yet
// come back). Returned results are counted; once every pixel of the layer has
// returned, done pulses for one cycle.
//
// Ports
//   clk, rst_n    single clock, asynchronous active-low reset
//   start         1-cycle pulse, begins a layer (only honoured in IDLE)
//   abort         1-cycle pulse, abandons the layer (no done)
//   cmd_valid     window command valid (registered)
//   cmd_ready     datapath accepts the command this cycle
//   cmd_kernel    kernel index
//   cmd_row       output row (window top-left)
//   cmd_col       output col (window top-left)
//   cmd_depth     channel slice
//   cmd_first     first slice of a pixel (clear accumulator)
//   cmd_last      last slice of a pixel (emit output pixel)
//   res_valid     datapath finished one output pixel
//   busy          scheduler is not IDLE
//   done          1-cycle pulse, layer complete
// -----------------------------------------------------------------------------
module conv_window_scheduler #(
    parameter int ROWS            = 20,
    parameter int COLS            = 20,
    parameter int DEPTH           = 8,
    parameter int KERNEL_SIZE     = 3,
    parameter int NUM_KERNELS     = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [$clog2(NUM_KERNELS)-1:0] cmd_kernel,
    output logic [$clog2(ROWS)-1:0]        cmd_row,
    output logic [$clog2(COLS)-1:0]        cmd_col,
    output logic [$clog2(DEPTH)-1:0]       cmd_depth,
    output logic                           cmd_first,
    output logic                           cmd_last,
    input  logic                           res_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int OUT_ROWS     = ROWS - KERNEL_SIZE + 1;
    localparam int OUT_COLS     = COLS - KERNEL_SIZE + 1;
    localparam int TOTAL_PIXELS = NUM_KERNELS * OUT_ROWS * OUT_COLS;

    localparam int KW = $clog2(NUM_KERNELS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DEPTH);
    localparam int PW = $clog2(TOTAL_PIXELS + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [KW-1:0] LAST_K    = KW'(NUM_KERNELS - 1);
    localparam logic [RW-1:0] LAST_R    = RW'(OUT_ROWS - 1);
    localparam logic [CW-1:0] LAST_C    = CW'(OUT_COLS - 1);
    localparam logic [DW-1:0] LAST_D    = DW'(DEPTH - 1);
    localparam logic [PW-1:0] TOTAL_PIX = PW'(TOTAL_PIXELS);
    localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_next;
    logic [PW-1:0] returned;

    logic          hs;
    logic          last_hs;
    logic          ret;
    logic          final_cmd;
    logic          issue_allowed;
    logic [KW-1:0] k_next;
    logic [RW-1:0] r_next;
    logic [CW-1:0] c_next;
    logic [DW-1:0] d_next;
    logic [DW-1:0] depth_after;

    assign hs        = cmd_valid & cmd_ready;
    assign cmd_first = cmd_valid & (cmd_depth == '0);
    assign cmd_last  = cmd_valid & (cmd_depth == LAST_D);
    assign last_hs   = hs & cmd_last;
    // A result with nothing outstanding (or while idle) is a stray pulse and
    // must not underflow the credit counter or advance the return count.
    assign ret       = res_valid & (outstanding != '0) & (state != S_IDLE);
    assign busy      = (state != S_IDLE);

    // Successor of the current command in the loop nest, depth innermost.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        d_next    = cmd_depth + DW'(1);
        c_next    = cmd_col;
        r_next    = cmd_row;
        k_next    = cmd_kernel;
        final_cmd = 1'b0;
        if (cmd_depth == LAST_D) begin
            d_next = '0;
            c_next = cmd_col + CW'(1);
            if (cmd_col == LAST_C) begin
                c_next = '0;
                r_next = cmd_row + RW'(1);
                if (cmd_row == LAST_R) begin
                    r_next = '0;
                    k_next = cmd_kernel + KW'(1);
                    if (cmd_kernel == LAST_K) begin
                        k_next    = '0;
                        final_cmd = 1'b1;
                    end
                end
            end
        end
    end

    // Credit bookkeeping: a pixel is charged when its last slice is accepted
    // and refunded when its result returns; both together cancel out.
    always_comb begin
        out_next = outstanding;
        if (last_hs && !ret) begin
            out_next = outstanding + OW'(1);
        end else if (!last_hs && ret) begin
            out_next = outstanding - OW'(1);
        end
    end

    // Only the first slice of a pixel waits for credit; the remaining slices
    // of a pixel that has already started always proceed.
    assign depth_after   = hs ? d_next : cmd_depth;
    assign issue_allowed = (depth_after != '0) || (out_next < MAX_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_valid   <= 1'b0;
            cmd_kernel  <= '0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            cmd_depth   <= '0;
            outstanding <= '0;
            returned    <= '0;
            done        <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    state       <= S_ISSUE;
                    cmd_valid   <= 1'b1;
                    cmd_kernel  <= '0;
                    cmd_row     <= '0;
                    cmd_col     <= '0;
                    cmd_depth   <= '0;
                    outstanding <= '0;
                    returned    <= '0;
                end
            end else if (abort) begin
                state       <= S_IDLE;
                cmd_valid   <= 1'b0;
                cmd_kernel  <= '0;
                cmd_row     <= '0;
                cmd_col     <= '0;
                cmd_depth   <= '0;
                outstanding <= '0;
                returned    <= '0;
            end else begin
                outstanding <= out_next;
                if (ret) begin
                    returned <= returned + PW'(1);
                end
                case (state)
                    S_ISSUE: begin
                        if (hs) begin
                            cmd_kernel <= k_next;
                            cmd_row    <= r_next;
                            cmd_col    <= c_next;
                            cmd_depth  <= d_next;
                        end
                        // The final successor wraps to all zeros, so the
                        // fields are already cleared when entering DRAIN.
                        if (hs && final_cmd) begin
                            state     <= S_DRAIN;
                            cmd_valid <= 1'b0;
                        end else begin
                            cmd_valid <= issue_allowed;
                        end
                    end
                    S_DRAIN: begin
                        if (returned == TOTAL_PIX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state       <= S_IDLE;
                        outstanding <= '0;
                        returned    <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_window_scheduler
//
// Directed bench for conv_window_scheduler with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. A loop-nest model
// predicts every accepted command; results are returned a fixed number of
// cycles after each accepted last slice unless deliberately withheld.
// -----------------------------------------------------------------------------
module tb_conv_window_scheduler;

    localparam int ROWS            = 20;
    localparam int COLS            = 20;
    localparam int DEPTH           = 8;
    localparam int KERNEL_SIZE     = 3;
    localparam int NUM_KERNELS     = 5;
    localparam int MAX_OUTSTANDING = 4;
    localparam int OR_N            = ROWS - KERNEL_SIZE + 1;            // 18
    localparam int OC_N            = COLS - KERNEL_SIZE + 1;            // 18
    localparam int NCMD            = NUM_KERNELS * OR_N * OC_N * DEPTH; // 12960
    localparam int RES_DELAY       = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_kernel;
    logic [4:0] cmd_row;
    logic [4:0] cmd_col;
    logic [2:0] cmd_depth;
    logic       cmd_first;
    logic       cmd_last;
    logic       res_valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    conv_window_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .KERNEL_SIZE(KERNEL_SIZE),
        .NUM_KERNELS(NUM_KERNELS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kernel(cmd_kernel), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_depth(cmd_depth), .cmd_first(cmd_first), .cmd_last(cmd_last),
        .res_valid(res_valid), .busy(busy), .done(done)
    );

    wire [15:0] fields = {cmd_kernel, cmd_row, cmd_col, cmd_depth};

    int checks = 0;
    int errors = 0;
    int exp_k, exp_r, exp_c, exp_d;
    int acc_cnt, done_cnt, cyc, first_acc, last_acc;
    int res_due[$];

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle();
        @(negedge clk);
        start     = 1'b0;
        abort     = 1'b0;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic reset_model();
        exp_k = 0; exp_r = 0; exp_c = 0; exp_d = 0;
        acc_cnt = 0; done_cnt = 0; first_acc = -1; last_acc = -1;
        res_due.delete();
    endtask

    // Pulse start (optionally with abort) and check the first command appears
    // on the following cycle as (0,0,0,0).
    task automatic start_layer(input bit with_abort);
        reset_model();
        @(negedge clk);
        start = 1'b1; abort = with_abort; cmd_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || busy !== 1'b1 || fields !== 16'h0 || cmd_first !== 1'b1) begin
            errors++;
            $display("FAIL start_first_cmd valid=%b busy=%b first=%b fields=%h required valid=1 busy=1 first=1 fields=0000",
                     cmd_valid, busy, cmd_first, fields);
        end
    endtask

    // Cycle loop: drives cmd_ready / res_valid, checks every accepted command
    // against the loop-nest model and that stalled commands hold still.
    task automatic run(input int stall_pct, input bit hold_res, input int stop_after,
                       input int poke_start, input int budget);
        bit         prev_stall;
        logic [15:0] prev_f;
        logic [17:0] got, want;
        int          post;
        prev_stall = 1'b0;
        prev_f     = '0;
        post       = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            abort = 1'b0;
            start = (poke_start > 0) && (i % poke_start == poke_start - 1)
                    && (acc_cnt > 0) && (acc_cnt < NCMD - 16);
            if (done === 1'b1) begin
                done_cnt++;
                post = 0;
            end
            if (prev_stall) begin
                checks++;
                if (cmd_valid !== 1'b1 || fields !== prev_f) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b fields=%h required valid=1 fields=%h",
                             cmd_valid, fields, prev_f);
                end
            end
            res_valid = 1'b0;
            if (!hold_res && res_due.size() > 0 && res_due[0] <= cyc) begin
                res_valid = 1'b1;
                void'(res_due.pop_front());
            end
            cmd_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            if (cmd_valid === 1'b1 && cmd_ready) begin
                got  = {fields, cmd_first, cmd_last};
                want = {3'(exp_k), 5'(exp_r), 5'(exp_c), 3'(exp_d),
                        exp_d == 0, exp_d == DEPTH - 1};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL cmd_order #%0d got k/r/c/d/f/l=%0d/%0d/%0d/%0d/%b/%b required %0d/%0d/%0d/%0d/%b/%b",
                             acc_cnt, cmd_kernel, cmd_row, cmd_col, cmd_depth, cmd_first, cmd_last,
                             exp_k, exp_r, exp_c, exp_d, exp_d == 0, exp_d == DEPTH - 1);
                end
                if (exp_d == DEPTH - 1) res_due.push_back(cyc + RES_DELAY);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
                exp_d++;
                if (exp_d == DEPTH) begin
                    exp_d = 0; exp_c++;
                    if (exp_c == OC_N) begin
                        exp_c = 0; exp_r++;
                        if (exp_r == OR_N) begin
                            exp_r = 0; exp_k++;
                        end
                    end
                end
            end
            prev_stall = (cmd_valid === 1'b1) && !cmd_ready;
            prev_f     = fields;
            if (stop_after > 0 && acc_cnt >= stop_after) return;
            if (post >= 0) begin
                post++;
                if (post > 3) return;
            end
            if (errors > 20) return;
        end
    endtask

    task automatic abort_layer();
        @(negedge clk);
        abort = 1'b1; start = 1'b0; cmd_ready = 1'b0; res_valid = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0; res_valid = 1'b0;
        cyc = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, fields, cmd_first, cmd_last, busy, done} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b fields=%h first=%b last=%b busy=%b done=%b required all 0",
                     cmd_valid, fields, cmd_first, cmd_last, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) idle_cycle();
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b valid=%b done=%b required 0/0/0", busy, cmd_valid, done);
        end
    endtask

    task automatic test_full_layer();
        start_layer(1'b0);
        run(0, 1'b0, 0, 0, NCMD + 200);
        checks++;
        if (acc_cnt !== NCMD) begin
            errors++;
            $display("FAIL full_cmd_count got %0d required %0d", acc_cnt, NCMD);
        end
        checks++;
        if (last_acc - first_acc + 1 !== NCMD) begin
            errors++;
            $display("FAIL back_to_back_span got %0d cycles required %0d", last_acc - first_acc + 1, NCMD);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL full_done_count got %0d required 1", done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_idle_after_done busy=%b required 0", busy);
        end
    endtask

    task automatic test_credit();
        start_layer(1'b0);
        // Stray result before any pixel is outstanding: must not create credit.
        @(negedge clk);
        res_valid = 1'b1; cmd_ready = 1'b0;
        idle_cycle();
        run(0, 1'b1, 0, 0, 100);
        checks++;
        if (acc_cnt !== MAX_OUTSTANDING * DEPTH) begin
            errors++;
            $display("FAIL credit_block_count got %0d required %0d", acc_cnt, MAX_OUTSTANDING * DEPTH);
        end
        checks++;
        if (cmd_valid !== 1'b0 || fields !== {3'd0, 5'd0, 5'd4, 3'd0}) begin
            errors++;
            $display("FAIL credit_blocked_state valid=%b fields=%h required valid=0 fields=%h",
                     cmd_valid, fields, {3'd0, 5'd0, 5'd4, 3'd0});
        end
        @(negedge clk);
        res_valid = 1'b1; cmd_ready = 1'b0;
        idle_cycle();
        run(0, 1'b1, 0, 0, 60);
        checks++;
        if (acc_cnt !== (MAX_OUTSTANDING + 1) * DEPTH) begin
            errors++;
            $display("FAIL credit_resume_count got %0d required %0d", acc_cnt, (MAX_OUTSTANDING + 1) * DEPTH);
        end
        abort_layer();
    endtask

    task automatic test_random_stall();
        start_layer(1'b0);
        run(40, 1'b0, 2000, 0, 8000);
        checks++;
        if (acc_cnt !== 2000) begin
            errors++;
            $display("FAIL stall_cmd_count got %0d required 2000", acc_cnt);
        end
        abort_layer();
    endtask

    task automatic test_abort();
        start_layer(1'b0);
        run(0, 1'b0, 100, 0, 400);
        // start together with abort outside IDLE: abort wins
        @(negedge clk);
        abort = 1'b1; start = 1'b1; cmd_ready = 1'b0; res_valid = 1'b0;
        idle_cycle();
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || fields !== 16'h0) begin
            errors++;
            $display("FAIL abort_idle busy=%b valid=%b fields=%h required 0/0/0000", busy, cmd_valid, fields);
        end
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done cycles required 0", done_cnt);
        end
        // start together with abort in IDLE: start wins, restart from zero
        start_layer(1'b1);
        run(0, 1'b0, 20, 0, 100);
        checks++;
        if (acc_cnt !== 20) begin
            errors++;
            $display("FAIL restart_cmd_count got %0d required 20", acc_cnt);
        end
        abort_layer();
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            res_valid = 1'b1; start = 1'b0; cmd_ready = 1'b0;
        end
        idle_cycle();
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stray_res_idle busy=%b valid=%b done=%b required 0/0/0", busy, cmd_valid, done);
        end
        start_layer(1'b0);
        run(0, 1'b0, 0, 53, NCMD + 200);
        checks++;
        if (acc_cnt !== NCMD || done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_start_layer cmds=%0d dones=%0d required %0d/1", acc_cnt, done_cnt, NCMD);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_async_reset();
        start_layer(1'b0);
        run(0, 1'b0, 50, 0, 200);
        @(negedge clk);
        cmd_ready = 1'b0; res_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, fields, cmd_first, cmd_last, busy, done} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset got valid=%b fields=%h first=%b last=%b busy=%b done=%b required all 0",
                     cmd_valid, fields, cmd_first, cmd_last, busy, done);
        end
        idle_cycle();
        rst_n = 1'b1;
        repeat (2) idle_cycle();
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_async_reset busy=%b valid=%b required 0/0", busy, cmd_valid);
        end
        start_layer(1'b0);
        run(0, 1'b0, 0, 0, NCMD + 200);
        checks++;
        if (acc_cnt !== NCMD || done_cnt !== 1) begin
            errors++;
            $display("FAIL post_reset_layer cmds=%0d dones=%0d required %0d/1", acc_cnt, done_cnt, NCMD);
        end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_credit();
        test_random_stall();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
